// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - execute-stage branch resolution, fetch redirect and predictor training
module branch_resolve_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallE,
  input  logic             flushE,
  input  logic             stallM,
  input  logic             flushM,
  input  logic             branchD,
  input  logic             branchL_D,
  input  logic             pred_takeD,
  input  logic [2:0]       cmp_typeD,
  input  logic [31:0]      pcD,
  input  logic [31:0]      targetD,
  input  logic [31:0]      rs_valueE,
  input  logic [31:0]      rt_valueE,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             kill_f,
  output logic             annul_d,
  output logic             branchM,
  output logic             actual_takeM,
  output logic [31:0]      pcM,
  output logic             mispredM,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic {IDLE, PENDING} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic        branchE, branchL_E, predTakeE;
  logic [2:0]  cmpTypeE;
  logic [31:0] pcE, targetE;

  logic        condE, actualTakeE, mispredE;
  logic [31:0] correctPc;

  state_t      state, nextState;
  logic [31:0] pendPc;

  logic        branchMReg, mispredMReg, advancedM;

  // ID/EX register; a flush only needs to kill the branch bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branchE   <= 1'b0;
      branchL_E <= 1'b0;
      predTakeE <= 1'b0;
      cmpTypeE  <= 3'd0;
      pcE       <= 32'd0;
      targetE   <= 32'd0;
    end else if (flushE) begin
      branchE   <= 1'b0;
      branchL_E <= 1'b0;
    end else if (!stallE) begin
      branchE   <= branchD;
      branchL_E <= branchL_D;
      predTakeE <= pred_takeD;
      cmpTypeE  <= cmp_typeD;
      pcE       <= pcD;
      targetE   <= targetD;
    end
  end

  always_comb begin
    condE = 1'b0;
    case (cmpTypeE)
      3'd0:    condE = (rs_valueE == rt_valueE);
      3'd1:    condE = (rs_valueE != rt_valueE);
      3'd2:    condE = rs_valueE[31] | (rs_valueE == 32'd0);
      3'd3:    condE = ~rs_valueE[31] & (rs_valueE != 32'd0);
      3'd4:    condE = rs_valueE[31];
      3'd5:    condE = ~rs_valueE[31];
      default: condE = 1'b0;
    endcase
  end

  // resolution only counts in the cycle the branch leaves E
  assign actualTakeE = branchE & condE;
  assign mispredE    = branchE & (actualTakeE != predTakeE) & ~stallM;
  assign correctPc   = actualTakeE ? targetE : pcE + 32'd8;
  assign annul_d     = branchE & branchL_E & ~actualTakeE & ~stallM;

  always_comb begin
    nextState      = state;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    kill_f         = 1'b0;
    case (state)
      IDLE: begin
        if (mispredE) begin
          redirect_valid = 1'b1;
          redirect_pc    = correctPc;
          kill_f         = 1'b1;
          if (!redirect_ready) nextState = PENDING;
        end
      end
      PENDING: begin
        redirect_valid = 1'b1;
        redirect_pc    = pendPc;
        kill_f         = 1'b1;
        if (redirect_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pendPc <= 32'd0;
    end else begin
      state <= nextState;
      if (state == IDLE && mispredE && !redirect_ready) pendPc <= correctPc;
    end
  end

  // EX/MEM register; advancedM marks the first cycle of a freshly loaded entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branchMReg   <= 1'b0;
      actual_takeM <= 1'b0;
      pcM          <= 32'd0;
      mispredMReg  <= 1'b0;
      advancedM    <= 1'b0;
    end else begin
      advancedM <= ~stallM;
      if (flushM) begin
        branchMReg  <= 1'b0;
        mispredMReg <= 1'b0;
      end else if (!stallM) begin
        branchMReg   <= branchE;
        actual_takeM <= actualTakeE;
        pcM          <= pcE;
        mispredMReg  <= mispredE;
      end
    end
  end

  assign branchM  = branchMReg & advancedM;
  assign mispredM = mispredMReg & advancedM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (branchM && branch_cnt != '1) branch_cnt <= branch_cnt + CNT_ONE;
      if (mispredM && mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_ONE;
    end
  end

endmodule
